gray_counter: RTL and testbench

- Parameterised synchronous Gray-code counter; the upstream stage feeding the team's 4-bit Gray-to-binary converter.
- Produces a registered, glitch-free Gray count for that converter and for pointer/position logic.
- Keeps an internal binary count; exports it alongside the Gray value so the bench can cross-check the downstream converter.
- Supports enable, up/down direction, synchronous clear, synchronous load from a binary value, and a one-cycle wrap pulse.

---
 rtl/gray_counter_if.sv | 26 ++
 rtl/gray_counter.sv | 58 +++++
 tb/tb_gray_counter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gray_counter_if.sv
// Bus bundle for the Gray-code counter: control strobes in, count and flags out.
interface gray_counter_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic             en;
    logic             up_dn;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] binary;
    logic             wrap;
    logic             at_max;

    // Controller side: drives the strobes, observes the count.
    modport master (
        output clr, load, load_bin, en, up_dn,
        input  gray, binary, wrap, at_max
    );

    // Counter side: samples the strobes, drives the count.
    modport slave (
        input  clr, load, load_bin, en, up_dn,
        output gray, binary, wrap, at_max
    );
endinterface

// File: rtl/gray_counter.sv
// Parameterised Gray-code counter with binary shadow, clear, load, up/down and wrap pulse.
// WIDTH must be at least 2.
module gray_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    gray_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             next_wrap;

    // Next binary value by priority clr > load > count; wrap only on en-driven roll-over.
    always_comb begin
        next_bin  = bin_q;
        next_wrap = 1'b0;
        if (bus.clr) begin
            next_bin = '0;
        end else if (bus.load) begin
            next_bin = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                next_bin  = bin_q + ONE;
                next_wrap = (bin_q == MAX_VAL);
            end else begin
                next_bin  = bin_q - ONE;
                next_wrap = (bin_q == '0);
            end
        end
        next_gray = next_bin ^ (next_bin >> 1);
    end

    // Binary, Gray and wrap registers share one edge so gray is never decoded combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= next_bin;
            gray_q <= next_gray;
            wrap_q <= next_wrap;
        end
    end

    assign bus.binary = bin_q;
    assign bus.gray   = gray_q;
    assign bus.wrap   = wrap_q;
    assign bus.at_max = (bin_q == MAX_VAL);
endmodule

// File: tb/tb_gray_counter.sv
// Directed, table-driven bench for gray_counter (WIDTH=4).
module tb_gray_counter;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    gray_counter_if #(.WIDTH(W)) bus ();

    gray_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       clr;
        logic       load;
        logic [3:0] load_bin;
        logic       en;
        logic       up_dn;
        logic [3:0] e_bin;
        logic [3:0] e_gray;
        logic       e_wrap;
        logic       e_max;
    } vec_t;

    vec_t vecs[$];

    // Gray-to-binary reference decode.
    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic clr, input logic load,
                       input logic [3:0] lb, input logic en, input logic up_dn,
                       input logic [3:0] e_bin, input logic [3:0] e_gray,
                       input logic e_wrap, input logic e_max);
        vec_t v;
        v.name = name; v.clr = clr; v.load = load; v.load_bin = lb;
        v.en = en; v.up_dn = up_dn; v.e_bin = e_bin; v.e_gray = e_gray;
        v.e_wrap = e_wrap; v.e_max = e_max;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic clr, input logic load, input logic [3:0] lb,
                         input logic en, input logic up_dn);
        bus.clr = clr; bus.load = load; bus.load_bin = lb; bus.en = en; bus.up_dn = up_dn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [3:0] b, input logic [3:0] g,
                           input logic w, input logic m);
        chk({name, ".binary"}, 32'(bus.binary), 32'(b));
        chk({name, ".gray"},   32'(bus.gray),   32'(g));
        chk({name, ".wrap"},   32'(bus.wrap),   32'(w));
        chk({name, ".at_max"}, 32'(bus.at_max), 32'(m));
    endtask

    logic [3:0] up_gray [16];
    logic [3:0] prev_gray;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

        up_gray = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // Full up-count from 0 over 17 edges: back to 0 with wrap, then 1.
        for (int i = 1; i <= 17; i++) begin
            add($sformatf("up%0d", i), 1'b0, 1'b0, 4'h0, 1'b1, 1'b1,
                4'(i % 16), up_gray[i % 16], (i == 16), (i == 15));
        end
        add("clr0",     1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0);
        add("dn_wrap",  1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'hF, 4'b1000, 1'b1, 1'b1);
        add("dn_e",     1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'hE, 4'b1001, 1'b0, 1'b0);
        add("load5",    1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 4'h5, 4'b0111, 1'b0, 1'b0);
        add("load_en",  1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 4'hF, 4'b1000, 1'b0, 1'b1);
        add("up_wrap",  1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b1, 1'b0);
        add("hold0",    1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0);
        add("dn_wrap2", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'hF, 4'b1000, 1'b1, 1'b1);
        add("up_wrap2", 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b1, 1'b0);
        add("loadF",    1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 4'hF, 4'b1000, 1'b0, 1'b1);
        add("load0_en", 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0);
        add("loadA",    1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 4'hA, 4'b1111, 1'b0, 1'b0);
        add("clr_all",  1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0);
        add("dn_after", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'hF, 4'b1000, 1'b1, 1'b1);
        add("clr_max",  1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0);

        // Reset held for 3 cycles: outputs stay at zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all($sformatf("rst%0d", i), 4'h0, 4'h0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;

        // Idle with en=0 for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all($sformatf("idle%0d", i), 4'h0, 4'h0, 1'b0, 1'b0);
        end

        // Apply the vector table.
        foreach (vecs[i]) begin
            prev_gray = bus.gray;
            drive(vecs[i].clr, vecs[i].load, vecs[i].load_bin, vecs[i].en, vecs[i].up_dn);
            step();
            chk_all(vecs[i].name, vecs[i].e_bin, vecs[i].e_gray, vecs[i].e_wrap, vecs[i].e_max);
            chk({vecs[i].name, ".decode"}, 32'(g2b(bus.gray)), 32'(bus.binary));
            if (vecs[i].en && !vecs[i].clr && !vecs[i].load)
                chk({vecs[i].name, ".hamming"}, 32'($countones(prev_gray ^ bus.gray)), 32'd1);
        end

        // Reset mid-count: count up to 7, then drop rst_n between edges.
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step();
        chk_all("pre_rst", 4'h7, 4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("rst_hold", 4'h0, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_all("rst_release", 4'h1, 4'b0001, 1'b0, 1'b0);

        // Wrap pulse in flight is cancelled by reset.
        drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        step();
        chk_all("wrap_pre", 4'h0, 4'h0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("wrap_cancel", 32'(bus.wrap), 32'd0);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("post_rst_hold", 4'h0, 4'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
